pulse_former: RTL and testbench

//  Consumer end of the delay-to-pulse launch interface in the OSG chain.

---
 rtl/osg_pkg.sv | 26 ++
 rtl/pl_timebase.sv | 51 +++++
 rtl/pulse_former.sv | 152 +++++++++++++++
 tb/tb_pulse_former.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/osg_pkg.sv
//------------------------------------------------------------------------------
// Module  : osg_pkg
// Brief   : Shared OSG definitions: timebase codes, divider defaults, FSM states.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package osg_pkg;

  localparam logic [4:0] MLT_CLK  = 5'd1;
  localparam logic [4:0] MLT_MID  = 5'd2;
  localparam logic [4:0] MLT_SLOW = 5'd3;

  localparam int DIV_MID_DEFAULT  = 100;
  localparam int DIV_SLOW_DEFAULT = 100000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } pl_state_e;

endpackage

`default_nettype wire

// File: rtl/pl_timebase.sv
//------------------------------------------------------------------------------
// Module  : pl_timebase
// Brief   : Prescaler producing a one-cycle tick every 1/DIV_MID/DIV_SLOW clocks.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pl_timebase
  import osg_pkg::*;
#(
  parameter int DIV_MID  = DIV_MID_DEFAULT,
  parameter int DIV_SLOW = DIV_SLOW_DEFAULT
) (
  input  logic       clk_Pulse,
  input  logic       rst_n,
  input  logic       clr,
  input  logic [4:0] code,
  output logic       tick
);

  localparam int DIV_MAX = (DIV_SLOW > DIV_MID) ? DIV_SLOW : DIV_MID;
  localparam int CNT_W   = $clog2(DIV_MAX + 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_limit;

  // Unknown codes fall back to the raw clock.
  always_comb begin
    w_limit = '0;
    case (code)
      MLT_MID:  w_limit = CNT_W'(DIV_MID - 1);
      MLT_SLOW: w_limit = CNT_W'(DIV_SLOW - 1);
      default:  w_limit = '0;
    endcase
  end

  always_ff @(posedge clk_Pulse or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || (r_cnt == w_limit)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == w_limit);

endmodule

`default_nettype wire

// File: rtl/pulse_former.sv
//------------------------------------------------------------------------------
// Module  : pulse_former
// Brief   : Launch-edge triggered light pulse generator; burst mode when
//           PULSE_FORMER_PL_BURST_EN is defined.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pulse_former
  import osg_pkg::*;
#(
  parameter int LEN_W    = 17,
  parameter int NUM_W    = 8,
  parameter int DIV_MID  = DIV_MID_DEFAULT,
  parameter int DIV_SLOW = DIV_SLOW_DEFAULT
) (
  input  logic             clk_Pulse,
  input  logic             rst_n,
  input  logic             launch_PL,
  input  logic [LEN_W-1:0] pl_len,
  input  logic [LEN_W-1:0] pl_gap,
  input  logic [NUM_W-1:0] pl_num,
  input  logic [4:0]       pl_mlt,
  output logic             PL_out,
  output logic             PL_busy,
  output logic             PL_done
);

  pl_state_e        r_state;
  pl_state_e        w_next;
  logic             r_launch_q;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_tcnt;
  logic [4:0]       r_mlt;
  logic             r_out;
  logic             r_busy;
  logic             r_done;
  logic             w_start;
  logic             w_tick;
  logic             w_clr;
  logic             w_len_hit;
  logic             w_last;

`ifdef PULSE_FORMER_PL_BURST_EN
  logic [LEN_W-1:0] r_gap;
  logic [NUM_W-1:0] r_num;
  logic [NUM_W-1:0] r_pcnt;
  logic             w_gap_hit;

  assign w_last    = (r_pcnt == (r_num - NUM_W'(1)));
  assign w_gap_hit = (r_gap == '0) || (w_tick && (r_tcnt == (r_gap - LEN_W'(1))));
`else
  logic w_unused;

  assign w_unused = ^{pl_gap, pl_num};
  assign w_last   = 1'b1;
`endif

  assign w_start   = launch_PL & ~r_launch_q;
  assign w_len_hit = w_tick && (r_tcnt == (r_len - LEN_W'(1)));
  // Realign the prescaler whenever a pulse begins so its width is exact.
  assign w_clr     = (r_state == ST_IDLE) || ((r_state == ST_GAP) && (w_next == ST_PULSE));

  pl_timebase #(
    .DIV_MID  (DIV_MID),
    .DIV_SLOW (DIV_SLOW)
  ) u_timebase (
    .clk_Pulse (clk_Pulse),
    .rst_n     (rst_n),
    .clr       (w_clr),
    .code      (r_mlt),
    .tick      (w_tick)
  );

  always_ff @(posedge clk_Pulse or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Abort (launch low) outranks tick completion in every active state.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_next = (pl_len == '0) ? ST_DONE : ST_PULSE;
      end
      ST_PULSE: begin
        if (!launch_PL)     w_next = ST_IDLE;
        else if (w_len_hit) w_next = w_last ? ST_DONE : ST_GAP;
      end
`ifdef PULSE_FORMER_PL_BURST_EN
      ST_GAP: begin
        if (!launch_PL)     w_next = ST_IDLE;
        else if (w_gap_hit) w_next = ST_PULSE;
      end
`endif
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_Pulse or negedge rst_n) begin
    if (!rst_n) begin
      r_launch_q <= 1'b0;
      r_len      <= '0;
      r_mlt      <= '0;
      r_tcnt     <= '0;
      r_out      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef PULSE_FORMER_PL_BURST_EN
      r_gap      <= '0;
      r_num      <= '0;
      r_pcnt     <= '0;
`endif
    end else begin
      r_launch_q <= launch_PL;
      r_out      <= (w_next == ST_PULSE);
      r_busy     <= (w_next == ST_PULSE) || (w_next == ST_GAP);
      r_done     <= (w_next == ST_DONE);
      if (r_state == ST_IDLE) begin
        r_tcnt <= '0;
        if (w_start) begin
          r_len <= pl_len;
          r_mlt <= pl_mlt;
`ifdef PULSE_FORMER_PL_BURST_EN
          r_gap  <= pl_gap;
          r_num  <= (pl_num == '0) ? NUM_W'(1) : pl_num;
          r_pcnt <= '0;
`endif
        end
      end else if (w_next != r_state) begin
        r_tcnt <= '0;
`ifdef PULSE_FORMER_PL_BURST_EN
        if (r_state == ST_PULSE) r_pcnt <= r_pcnt + 1'b1;
`endif
      end else if (w_tick) begin
        r_tcnt <= r_tcnt + 1'b1;
      end
    end
  end

  assign PL_out  = r_out;
  assign PL_busy = r_busy;
  assign PL_done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_pulse_former.sv
//------------------------------------------------------------------------------
// Module  : tb_pulse_former
// Brief   : Directed self-checking bench for pulse_former.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pulse_former;

  logic        clk_Pulse = 1'b0;
  logic        rst_n     = 1'b0;
  logic        launch_PL = 1'b0;
  logic [16:0] pl_len    = '0;
  logic [16:0] pl_gap    = '0;
  logic [7:0]  pl_num    = '0;
  logic [4:0]  pl_mlt    = 5'd1;
  logic        PL_out;
  logic        PL_busy;
  logic        PL_done;

  int total = 0;
  int bad   = 0;
  int m_hi, m_dn, m_done_at, m_first, m_rises, m_busy;

  always #5 clk_Pulse = ~clk_Pulse;

  pulse_former dut (
    .clk_Pulse (clk_Pulse),
    .rst_n     (rst_n),
    .launch_PL (launch_PL),
    .pl_len    (pl_len),
    .pl_gap    (pl_gap),
    .pl_num    (pl_num),
    .pl_mlt    (pl_mlt),
    .PL_out    (PL_out),
    .PL_busy   (PL_busy),
    .PL_done   (PL_done)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Samples n cycles, 1ns after each rising edge.
  task automatic measure(input int n);
    logic prev;
    prev      = 1'b0;
    m_hi      = 0;
    m_dn      = 0;
    m_done_at = -1;
    m_first   = -1;
    m_rises   = 0;
    m_busy    = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk_Pulse);
      #1;
      if (PL_out) begin
        m_hi++;
        if (m_first < 0) m_first = i;
        if (!prev) m_rises++;
      end
      if (PL_done) begin
        m_dn++;
        m_done_at = i;
      end
      if (PL_busy) m_busy++;
      prev = PL_out;
    end
  endtask

  task automatic idle_gap();
    launch_PL = 1'b0;
    repeat (3) @(posedge clk_Pulse);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk_Pulse);
    #1;
    chk("reset_out",  int'(PL_out),  0);
    chk("reset_busy", int'(PL_busy), 0);
    chk("reset_done", int'(PL_done), 0);
    rst_n = 1'b1;
    @(posedge clk_Pulse);
    #1;

    // Single pulse, raw clock
    pl_mlt = 5'd1; pl_len = 17'd5; launch_PL = 1'b1;
    measure(10);
    chk("single_width",   m_hi, 5);
    chk("single_latency", m_first, 0);
    chk("single_done_n",  m_dn, 1);
    chk("single_done_at", m_done_at, 5);
    chk("single_busy",    m_busy, 5);
    pl_len = 17'd9;
    measure(6);
    chk("no_retrigger_hi", m_hi, 0);
    chk("no_retrigger_dn", m_dn, 0);
    idle_gap();

    // Mid timebase
    pl_mlt = 5'd2; pl_len = 17'd3; launch_PL = 1'b1;
    measure(310);
    chk("mid_width",   m_hi, 300);
    chk("mid_done_at", m_done_at, 300);
    idle_gap();

    // Unknown code behaves as raw clock
    pl_mlt = 5'd7; pl_len = 17'd3; launch_PL = 1'b1;
    measure(8);
    chk("code7_width",   m_hi, 3);
    chk("code7_done_at", m_done_at, 3);
    idle_gap();

    // Zero length
    pl_mlt = 5'd1; pl_len = 17'd0; launch_PL = 1'b1;
    measure(5);
    chk("zero_width",   m_hi, 0);
    chk("zero_done_n",  m_dn, 1);
    chk("zero_done_at", m_done_at, 0);
    chk("zero_busy",    m_busy, 0);
    idle_gap();

    // Abort at clock 40, then a full relaunch
    pl_mlt = 5'd1; pl_len = 17'd100; launch_PL = 1'b1;
    measure(40);
    chk("abort_pre_hi", m_hi, 40);
    launch_PL = 1'b0;
    measure(5);
    chk("abort_hi",   m_hi, 0);
    chk("abort_dn",   m_dn, 0);
    chk("abort_busy", m_busy, 0);
    launch_PL = 1'b1;
    measure(105);
    chk("relaunch_width",   m_hi, 100);
    chk("relaunch_done_at", m_done_at, 100);
    chk("relaunch_done_n",  m_dn, 1);
    idle_gap();

`ifdef PULSE_FORMER_PL_BURST_EN
    // Burst 4H 6L 4H 6L 4H
    pl_mlt = 5'd1; pl_len = 17'd4; pl_gap = 17'd6; pl_num = 8'd3; launch_PL = 1'b1;
    measure(30);
    chk("burst_hi",      m_hi, 12);
    chk("burst_rises",   m_rises, 3);
    chk("burst_done_n",  m_dn, 1);
    chk("burst_done_at", m_done_at, 24);
    chk("burst_busy",    m_busy, 24);
    idle_gap();

    pl_num = 8'd0; launch_PL = 1'b1;
    measure(10);
    chk("num0_rises",   m_rises, 1);
    chk("num0_done_at", m_done_at, 4);
    idle_gap();

    pl_gap = 17'd0; pl_num = 8'd2; launch_PL = 1'b1;
    measure(15);
    chk("gap0_hi",      m_hi, 8);
    chk("gap0_rises",   m_rises, 2);
    chk("gap0_done_at", m_done_at, 9);
    idle_gap();
    pl_num = 8'd1;
`endif

    // Reset mid-pulse, launch held across release
    pl_mlt = 5'd1; pl_len = 17'd50; launch_PL = 1'b1;
    measure(10);
    chk("rst_pre_hi", m_hi, 10);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_async_out",  int'(PL_out),  0);
    chk("rst_async_busy", int'(PL_busy), 0);
    repeat (2) @(posedge clk_Pulse);
    #1;
    rst_n = 1'b1;
    measure(60);
    chk("rst_relaunch_hi",      m_hi, 50);
    chk("rst_relaunch_rises",   m_rises, 1);
    chk("rst_relaunch_done_at", m_done_at, 50);
    idle_gap();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
